mem_stage: RTL

//  Memory-access stage of the 5-stage RV64 pipeline. Consumes the EX/MEM register outputs (MEM_*) under a valid/ready handshake.

---
 rtl/mem_stage.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV64 memory-access stage: dmem req/ack transactions, lane alignment, load extension
// One-entry WB output register; loads and stores hold the stage in BUSY until dmem_ack.
module mem_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              mem_ready,
  input  logic              MEM_w_ena,
  input  logic [4:0]        MEM_w_addr,
  input  logic [DATA_W-1:0] MEM_w_data,
  input  logic [2:0]        MEM_memrop,
  input  logic [2:0]        MEM_memwop,
  input  logic              MEM_mem_ena,
  input  logic              MEM_mem_wr,
  input  logic [ADDR_W-1:0] MEM_mem_addr,
  input  logic [DATA_W-1:0] MEM_mem_stor_data,
  input  logic [63:0]       MEM_pc,
  input  logic [31:0]       MEM_instr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_valid,
  input  logic              wb_ready,
  output logic              WB_w_ena,
  output logic [4:0]        WB_w_addr,
  output logic [DATA_W-1:0] WB_w_data,
  output logic [63:0]       WB_pc,
  output logic [31:0]       WB_instr,
  output logic              misalign_err
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t r_state, w_state_nxt;

  logic              r_mem_valid;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic [7:0]        r_dmem_wmask;
  logic              r_misalign_err;
  logic              r_wb_w_ena;
  logic [4:0]        r_wb_w_addr;
  logic [DATA_W-1:0] r_wb_w_data;
  logic [63:0]       r_wb_pc;
  logic [31:0]       r_wb_instr;

  // Operation captured at issue time, replayed into WB on dmem_ack
  logic              r_wr;
  logic [2:0]        r_rop;
  logic [2:0]        r_off;
  logic              r_w_ena;
  logic [4:0]        r_w_addr;
  logic [DATA_W-1:0] r_w_data;
  logic [63:0]       r_pc;
  logic [31:0]       r_instr;

  logic              w_out_free;
  logic              w_mem_ready;
  logic              w_accept;
  logic              w_st_ok;
  logic              w_is_mem;
  logic [1:0]        w_size;
  logic              w_misaligned;
  logic [7:0]        w_base;
  logic [7:0]        w_wmask;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]        w_off;
  logic              w_pass;
  logic              w_issue;
  logic              w_complete;
  logic              w_set_err;
  logic [DATA_W-1:0] w_rshift;
  logic [DATA_W-1:0] w_load_data;

  assign w_off       = MEM_mem_addr[2:0];
  assign w_out_free  = !r_mem_valid || wb_ready;
  assign w_mem_ready = (r_state == S_IDLE) && w_out_free;
  assign w_accept    = ex_valid && w_mem_ready;
  assign w_st_ok     = (MEM_memwop != 3'd0) && (MEM_memwop <= 3'd4);
  assign w_is_mem    = MEM_mem_ena && (MEM_mem_wr ? w_st_ok : (MEM_memrop != 3'd0));

  // Access size as log2(bytes); only meaningful when w_is_mem
  always_comb begin
    w_size = 2'd0;
    if (MEM_mem_wr) begin
      w_size = 2'(MEM_memwop - 3'd1);
    end else begin
      case (MEM_memrop)
        3'd1, 3'd5: w_size = 2'd0;
        3'd2, 3'd6: w_size = 2'd1;
        3'd3, 3'd7: w_size = 2'd2;
        3'd4:       w_size = 2'd3;
        default:    w_size = 2'd0;
      endcase
    end
  end

  always_comb begin
    w_misaligned = 1'b0;
    w_base       = 8'h01;
    case (w_size)
      2'd0: begin w_misaligned = 1'b0;              w_base = 8'h01; end
      2'd1: begin w_misaligned = w_off[0];          w_base = 8'h03; end
      2'd2: begin w_misaligned = |w_off[1:0];       w_base = 8'h0F; end
      default: begin w_misaligned = |w_off;         w_base = 8'hFF; end
    endcase
  end

  assign w_wmask = w_base << w_off;
  assign w_wdata = MEM_mem_stor_data << {w_off, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    w_pass      = 1'b0;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem || w_misaligned) begin
            w_pass    = 1'b1;
            w_set_err = w_is_mem;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_rshift = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_data = w_rshift;
    case (r_rop)
      3'd1:    w_load_data = {{56{w_rshift[7]}},  w_rshift[7:0]};
      3'd2:    w_load_data = {{48{w_rshift[15]}}, w_rshift[15:0]};
      3'd3:    w_load_data = {{32{w_rshift[31]}}, w_rshift[31:0]};
      3'd5:    w_load_data = {56'd0, w_rshift[7:0]};
      3'd6:    w_load_data = {48'd0, w_rshift[15:0]};
      3'd7:    w_load_data = {32'd0, w_rshift[31:0]};
      default: w_load_data = w_rshift;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_valid    <= 1'b0;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_wdata   <= '0;
      r_dmem_wmask   <= 8'h00;
      r_misalign_err <= 1'b0;
      r_wb_w_ena     <= 1'b0;
      r_wb_w_addr    <= 5'd0;
      r_wb_w_data    <= '0;
      r_wb_pc        <= 64'd0;
      r_wb_instr     <= 32'd0;
      r_wr           <= 1'b0;
      r_rop          <= 3'd0;
      r_off          <= 3'd0;
      r_w_ena        <= 1'b0;
      r_w_addr       <= 5'd0;
      r_w_data       <= '0;
      r_pc           <= 64'd0;
      r_instr        <= 32'd0;
    end else begin
      if (r_mem_valid && wb_ready) r_mem_valid <= 1'b0;

      if (w_pass) begin
        r_wb_w_ena  <= MEM_w_ena && !w_set_err;
        r_wb_w_addr <= MEM_w_addr;
        r_wb_w_data <= MEM_w_data;
        r_wb_pc     <= MEM_pc;
        r_wb_instr  <= MEM_instr;
        r_mem_valid <= 1'b1;
        if (w_set_err) r_misalign_err <= 1'b1;
      end

      if (w_issue) begin
        r_wr         <= MEM_mem_wr;
        r_rop        <= MEM_memrop;
        r_off        <= w_off;
        r_w_ena      <= MEM_w_ena;
        r_w_addr     <= MEM_w_addr;
        r_w_data     <= MEM_w_data;
        r_pc         <= MEM_pc;
        r_instr      <= MEM_instr;
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= MEM_mem_wr;
        r_dmem_addr  <= {MEM_mem_addr[ADDR_W-1:3], 3'b000};
        r_dmem_wdata <= MEM_mem_wr ? w_wdata : '0;
        r_dmem_wmask <= MEM_mem_wr ? w_wmask : 8'h00;
      end

      if (w_complete) begin
        r_dmem_req  <= 1'b0;
        r_wb_w_ena  <= r_w_ena;
        r_wb_w_addr <= r_w_addr;
        r_wb_w_data <= r_wr ? r_w_data : w_load_data;
        r_wb_pc     <= r_pc;
        r_wb_instr  <= r_instr;
        r_mem_valid <= 1'b1;
      end
    end
  end

  assign mem_ready    = w_mem_ready;
  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign dmem_wmask   = r_dmem_wmask;
  assign mem_valid    = r_mem_valid;
  assign WB_w_ena     = r_wb_w_ena;
  assign WB_w_addr    = r_wb_w_addr;
  assign WB_w_data    = r_wb_w_data;
  assign WB_pc        = r_wb_pc;
  assign WB_instr     = r_wb_instr;
  assign misalign_err = r_misalign_err;

endmodule
